// File: rtl/stream_upsizer.sv
// stream_upsizer: packs a narrow valid/ready beat stream into wide words
// with per-lane keep bits and a packet-last flag. A last beat flushes a
// partial word, so a packet never shares an output word with the next one.
module stream_upsizer #(
  parameter int width_in_p = 8,
  parameter int ratio_p    = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [width_in_p-1:0]         data_i,
  input  logic                          last_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic [width_in_p*ratio_p-1:0] data_o,
  output logic [ratio_p-1:0]            keep_o,
  output logic                          last_o,
  output logic                          valid_o,
  input  logic                          ready_i
);

  localparam int width_out_lp = width_in_p * ratio_p;
  localparam int lane_w_lp    = (ratio_p > 1) ? $clog2(ratio_p) : 1;

  logic [width_out_lp-1:0] acc_data;
  logic [ratio_p-1:0]      acc_keep;
  logic [lane_w_lp-1:0]    lane_q;

  logic [width_out_lp-1:0] word_data;
  logic [ratio_p-1:0]      word_keep;
  logic                    accept;
  logic                    complete;
  logic                    lane_last;

  // The input side only stalls while a held word is not being drained, so
  // ready never depends on the incoming beat itself.
  assign ready_o   = ~valid_o | ready_i;
  assign accept    = valid_i & ready_o;
  assign lane_last = (lane_q == lane_w_lp'(ratio_p - 1));
  assign complete  = accept & (lane_last | last_i);

  // Merge the incoming beat into the accumulator view at the current lane.
  always_comb begin
    word_data = acc_data;
    word_keep = acc_keep;
    for (int k = 0; k < ratio_p; k++) begin
      if (lane_q == lane_w_lp'(k)) begin
        word_data[k*width_in_p +: width_in_p] = data_i;
        word_keep[k] = 1'b1;
      end
    end
  end

  // Accumulator: grows lane by lane, clears as soon as a word is handed off.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_data <= '0;
      acc_keep <= '0;
      lane_q   <= '0;
    end else if (complete) begin
      acc_data <= '0;
      acc_keep <= '0;
      lane_q   <= '0;
    end else if (accept) begin
      acc_data <= word_data;
      acc_keep <= word_keep;
      lane_q   <= lane_q + lane_w_lp'(1);
    end
  end

  // Output register: load a completed word (even while the previous one is
  // leaving), otherwise drop valid once the held word has been taken.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_o  <= '0;
      keep_o  <= '0;
      last_o  <= 1'b0;
      valid_o <= 1'b0;
    end else if (complete) begin
      data_o  <= word_data;
      keep_o  <= word_keep;
      last_o  <= last_i;
      valid_o <= 1'b1;
    end else if (valid_o & ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_upsizer.sv
// tb_stream_upsizer: directed and streaming checks of stream_upsizer with a
// queue-based scoreboard drained by an independent output monitor.
`timescale 1ns/1ps
module tb_stream_upsizer;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [7:0]  data_i;
  logic        last_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] data_o;
  logic [3:0]  keep_o;
  logic        last_o;
  logic        valid_o;
  logic        ready_i;

  int checks = 0;
  int passes = 0;
  int words_out = 0;
  int stall_count = 0;
  bit streaming = 1'b0;
  bit use_model = 1'b0;

  logic [36:0] exp_q[$];

  logic [31:0] model_data;
  logic [3:0]  model_keep;
  int          model_lane;

  stream_upsizer #(.width_in_p(8), .ratio_p(4)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (data_i),
    .last_i  (last_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .keep_o  (keep_o),
    .last_o  (last_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic expectWord(input logic [31:0] d, input logic [3:0] k, input logic l);
    exp_q.push_back({l, k, d});
  endtask

  task automatic modelBeat(input logic [7:0] d, input logic l);
    model_data[model_lane*8 +: 8] = d;
    model_keep[model_lane] = 1'b1;
    if (model_lane == 3 || l) begin
      expectWord(model_data, model_keep, l);
      model_data = '0;
      model_keep = '0;
      model_lane = 0;
    end else begin
      model_lane++;
    end
  endtask

  // Present one beat and hold it until the DUT accepts it (bounded).
  task automatic applyStimulus(input logic [7:0] d, input logic l);
    bit acc;
    int budget;
    data_i  = d;
    last_i  = l;
    valid_i = 1'b1;
    acc     = 1'b0;
    budget  = 0;
    while (!acc && budget < 200) begin
      @(negedge clk_i);
      acc = ready_o;
      if (streaming && !ready_o) stall_count++;
      @(posedge clk_i);
      #1;
      budget++;
    end
    if (!acc) checkOutput("accept_timeout", 64'd0, 64'd1);
    else if (use_model) modelBeat(d, l);
  endtask

  task automatic endBurst();
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic waitDrain();
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || valid_o) && budget < 1000) begin
      @(posedge clk_i);
      #1;
      budget++;
    end
    if (budget >= 1000) checkOutput("drain_timeout", 64'd0, 64'd1);
  endtask

  // Stimulus, with the output monitor forked off as a separate process.
  initial begin
    logic [36:0] exp_word;
    int          words_before;
    reset_i = 1'b1;
    data_i  = '0;
    last_i  = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    model_data = '0;
    model_keep = '0;
    model_lane = 0;

    fork
      forever begin
        @(negedge clk_i);
        if (!reset_i && valid_o && ready_i) begin
          words_out++;
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_word", {27'd0, last_o, keep_o, data_o}, 64'd0);
          end else begin
            exp_word = exp_q.pop_front();
            checkOutput("word", {27'd0, last_o, keep_o, data_o}, {27'd0, exp_word});
          end
        end
      end
    join_none

    repeat (3) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    checkOutput("reset_valid", {63'd0, valid_o}, 64'd0);
    checkOutput("reset_data",  {32'd0, data_o}, 64'd0);
    checkOutput("reset_keep",  {60'd0, keep_o}, 64'd0);
    checkOutput("reset_last",  {63'd0, last_o}, 64'd0);
    checkOutput("reset_ready", {63'd0, ready_o}, 64'd1);

    $display("[TB] full word");
    expectWord(32'h44332211, 4'b1111, 1'b0);
    applyStimulus(8'h11, 1'b0);
    applyStimulus(8'h22, 1'b0);
    applyStimulus(8'h33, 1'b0);
    checkOutput("valid_before_complete", {63'd0, valid_o}, 64'd0);
    applyStimulus(8'h44, 1'b0);
    checkOutput("valid_latency", {63'd0, valid_o}, 64'd1);
    endBurst();
    waitDrain();

    $display("[TB] partial packets");
    expectWord(32'h0000BBAA, 4'b0011, 1'b1);
    expectWord(32'h0000DDCC, 4'b0011, 1'b1);
    applyStimulus(8'hAA, 1'b0);
    applyStimulus(8'hBB, 1'b1);
    applyStimulus(8'hCC, 1'b0);
    applyStimulus(8'hDD, 1'b1);
    endBurst();
    waitDrain();

    $display("[TB] single-beat packet");
    expectWord(32'h0000005A, 4'b0001, 1'b1);
    applyStimulus(8'h5A, 1'b1);
    endBurst();
    waitDrain();

    $display("[TB] backpressure");
    ready_i = 1'b0;
    expectWord(32'h04030201, 4'b1111, 1'b0);
    expectWord(32'h08070605, 4'b1111, 1'b0);
    expectWord(32'h00000A09, 4'b0011, 1'b1);
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h02, 1'b0);
    applyStimulus(8'h03, 1'b0);
    applyStimulus(8'h04, 1'b0);
    fork
      begin
        applyStimulus(8'h05, 1'b0);
        applyStimulus(8'h06, 1'b0);
        applyStimulus(8'h07, 1'b0);
        applyStimulus(8'h08, 1'b0);
        applyStimulus(8'h09, 1'b0);
        applyStimulus(8'h0A, 1'b1);
        endBurst();
      end
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge clk_i);
          checkOutput("stall_ready", {63'd0, ready_o}, 64'd0);
          checkOutput("stall_data", {32'd0, data_o}, 64'h04030201);
        end
        @(posedge clk_i);
        #1;
        ready_i = 1'b1;
      end
    join
    waitDrain();

    $display("[TB] reset mid-word");
    applyStimulus(8'hE1, 1'b0);
    applyStimulus(8'hE2, 1'b0);
    reset_i = 1'b1;
    data_i  = 8'hFF;
    valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    endBurst();
    checkOutput("midreset_ready", {63'd0, ready_o}, 64'd1);
    checkOutput("midreset_valid", {63'd0, valid_o}, 64'd0);
    expectWord(32'h04030201, 4'b1111, 1'b0);
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h02, 1'b0);
    applyStimulus(8'h03, 1'b0);
    applyStimulus(8'h04, 1'b0);
    endBurst();
    waitDrain();

    $display("[TB] streaming");
    words_before = words_out;
    use_model = 1'b1;
    streaming = 1'b1;
    for (int i = 0; i < 400; i++) applyStimulus(8'($urandom_range(0, 255)), 1'b0);
    endBurst();
    streaming = 1'b0;
    use_model = 1'b0;
    waitDrain();
    checkOutput("stream_stalls", 64'(stall_count), 64'd0);
    checkOutput("stream_words", 64'(words_out - words_before), 64'd100);
    checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    repeat (3) @(posedge clk_i);
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
